global_header_writer: RTL and testbench

Transmit-side counterpart of the global-register byte loader. On START it latches one frame header (object count, X centre, Y centre, angle, zoom) and serializes it as 5 bytes on a valid/ready byte stream. It then forwards exactly OBJ_COUNT*BYTES_PER_OBJ object bytes from an upstream source and flags completion. It sits between the scene/control logic and the byte link that feeds the renderer's register loader.

---
 rtl/global_header_writer_pkg.sv | 56 +++++
 rtl/global_header_writer_if.sv | 51 +++++
 rtl/global_header_writer_byte_out_reg.sv | 37 +++
 rtl/global_header_writer.sv | 143 ++++++++++++++
 tb/tb_global_header_writer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/global_header_writer_pkg.sv
// -----------------------------------------------------------------------------
// global_header_writer_pkg
// Shared definitions for the frame header writer and its matching register
// loader on the receive side. Both sides import this package, so the header
// field order and the state encoding are defined in exactly one place.
//   - byte width, header field indices and header length
//   - FSM state encoding (legacy-compatible localparam constants)
//   - hdr_t: the five latched header fields
//   - hdr_field(): select one header field by index
//   - frame_bytes(): object payload length in bytes for one frame
// -----------------------------------------------------------------------------
package global_header_writer_pkg;

    localparam int BYTE_W       = 8;
    localparam int BYTES_LEFT_W = 12;  // 255 objects * 15 bytes = 3825 < 4096

    typedef logic [BYTE_W-1:0] byte_t;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] OBJ  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Header byte order on the link
    localparam logic [2:0] HDR_CNT  = 3'd0;
    localparam logic [2:0] HDR_X    = 3'd1;
    localparam logic [2:0] HDR_Y    = 3'd2;
    localparam logic [2:0] HDR_ANG  = 3'd3;
    localparam logic [2:0] HDR_ZOOM = 3'd4;
    localparam logic [2:0] HDR_LEN  = 3'd5;

    typedef struct packed {
        byte_t cnt;
        byte_t x;
        byte_t y;
        byte_t ang;
        byte_t zoom;
    } hdr_t;

    function automatic byte_t hdr_field(input hdr_t h, input logic [2:0] idx);
        case (idx)
            HDR_CNT:  return h.cnt;
            HDR_X:    return h.x;
            HDR_Y:    return h.y;
            HDR_ANG:  return h.ang;
            HDR_ZOOM: return h.zoom;
            default:  return '0;
        endcase
    endfunction

    function automatic logic [BYTES_LEFT_W-1:0] frame_bytes(input byte_t cnt, input int bpo);
        return BYTES_LEFT_W'(cnt) * BYTES_LEFT_W'(bpo);
    endfunction

endpackage

// File: rtl/global_header_writer_if.sv
// -----------------------------------------------------------------------------
// global_header_writer_if
// Bundles every non-clock/reset signal of the header writer:
//   control   : START, OBJ_COUNT, X_CENTER, Y_CENTER, ANGLE, ZOOM
//   upstream  : OBJ_DATA, OBJ_VALID (in), OBJ_READY (out)
//   downstream: WByt0, WVALID (out), WREADY (in)
//   status    : BUSY, HDR_DONE, FINISH, BC
// modport master: the writer itself; modport slave: its environment.
// -----------------------------------------------------------------------------
interface global_header_writer_if;
    import global_header_writer_pkg::*;

    logic       START;
    byte_t      OBJ_COUNT;
    byte_t      X_CENTER;
    byte_t      Y_CENTER;
    byte_t      ANGLE;
    byte_t      ZOOM;

    byte_t      OBJ_DATA;
    logic       OBJ_VALID;
    logic       OBJ_READY;

    byte_t      WByt0;
    logic       WVALID;
    logic       WREADY;

    logic       BUSY;
    logic       HDR_DONE;
    logic       FINISH;
    logic [2:0] BC;

    modport master (
        input  START, OBJ_COUNT, X_CENTER, Y_CENTER, ANGLE, ZOOM,
        input  OBJ_DATA, OBJ_VALID,
        output OBJ_READY,
        output WByt0, WVALID,
        input  WREADY,
        output BUSY, HDR_DONE, FINISH, BC
    );

    modport slave (
        output START, OBJ_COUNT, X_CENTER, Y_CENTER, ANGLE, ZOOM,
        output OBJ_DATA, OBJ_VALID,
        input  OBJ_READY,
        input  WByt0, WVALID,
        output WREADY,
        input  BUSY, HDR_DONE, FINISH, BC
    );

endinterface

// File: rtl/global_header_writer_byte_out_reg.sv
// -----------------------------------------------------------------------------
// byte_out_reg
// Registered output stage of the byte link.
//   load/load_data : place a new byte on the link (wins over draining, so a
//                    byte can be loaded in the same cycle the old one leaves)
//   ready          : downstream accept (WREADY)
//   data/valid     : WByt0/WVALID, both straight from flops
// While valid && !ready the byte and valid are held. A transfer with no new
// load empties the stage.
// -----------------------------------------------------------------------------
module byte_out_reg
    import global_header_writer_pkg::*;
(
    input  logic  ACLK,
    input  logic  ARESETn,
    input  logic  load,
    input  byte_t load_data,
    input  logic  ready,
    output byte_t data,
    output logic  valid
);

    // NOTE: state is written with non-blocking assignments so every flop in
    // the design samples pre-edge values, independent of block ordering.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/global_header_writer.sv
// -----------------------------------------------------------------------------
// global_header_writer
// On START, latches a 5-byte frame header and sends it on the byte link,
// then forwards OBJ_COUNT*BYTES_PER_OBJ object bytes from upstream and
// pulses FINISH.
//   ACLK, ARESETn : clock, asynchronous active-low reset
//   bus (master)  : control inputs, upstream/downstream byte handshakes and
//                   status outputs (see global_header_writer_if)
// Parameter BYTES_PER_OBJ (1..15): bytes per object record.
// -----------------------------------------------------------------------------
module global_header_writer
    import global_header_writer_pkg::*;
#(
    parameter int BYTES_PER_OBJ = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    global_header_writer_if.master bus
);

    logic [1:0]              state;
    hdr_t                    hdr_q;
    logic [BYTES_LEFT_W-1:0] bytes_left;
    logic [2:0]              bc;
    logic [3:0]              obj_byte_cnt;  // position inside current object, debug only
    logic                    hdr_done;

    logic                    out_load;
    byte_t                   out_data;
    byte_t                   wbyte;
    logic                    wvalid;

    logic                    xfer;
    logic                    obj_ready;
    logic                    up_hs;

    assign xfer      = wvalid && bus.WREADY;
    // Accept upstream only when the output stage is empty or draining this
    // cycle, so a new byte never overwrites one that has not left.
    assign obj_ready = (state == OBJ) && (bytes_left != '0) && (!wvalid || bus.WREADY);
    assign up_hs     = obj_ready && bus.OBJ_VALID;

    // Next byte for the output stage
    // NOTE: every always_comb output gets a default first so no path through
    // the case leaves it unassigned, which would infer a latch.
    always_comb begin
        out_load = 1'b0;
        out_data = '0;
        case (state)
            IDLE: begin
                if (bus.START) begin
                    out_load = 1'b1;
                    out_data = bus.OBJ_COUNT;
                end
            end
            HDR: begin
                // Preload the following field as the current one leaves: no bubbles.
                if (xfer && (bc != HDR_ZOOM)) begin
                    out_load = 1'b1;
                    out_data = hdr_field(hdr_q, bc + 3'd1);
                end
            end
            OBJ: begin
                if (up_hs) begin
                    out_load = 1'b1;
                    out_data = bus.OBJ_DATA;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state        <= IDLE;
            hdr_q        <= '0;
            bytes_left   <= '0;
            bc           <= '0;
            obj_byte_cnt <= '0;
            hdr_done     <= 1'b0;
        end else begin
            hdr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        hdr_q        <= {bus.OBJ_COUNT, bus.X_CENTER, bus.Y_CENTER,
                                         bus.ANGLE, bus.ZOOM};
                        bytes_left   <= frame_bytes(bus.OBJ_COUNT, BYTES_PER_OBJ);
                        bc           <= '0;
                        obj_byte_cnt <= '0;
                        state        <= HDR;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        if (bc == HDR_ZOOM) begin
                            bc       <= '0;
                            hdr_done <= 1'b1;
                            state    <= (bytes_left == '0) ? DONE : OBJ;
                        end else begin
                            bc <= bc + 3'd1;
                        end
                    end
                end
                OBJ: begin
                    if (up_hs) begin
                        bytes_left   <= bytes_left - BYTES_LEFT_W'(1);
                        obj_byte_cnt <= (obj_byte_cnt == 4'(BYTES_PER_OBJ - 1))
                                        ? 4'd0 : obj_byte_cnt + 4'd1;
                    end else if ((bytes_left == '0) && xfer) begin
                        // Last byte already loaded and now leaving.
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    byte_out_reg u_byte_out_reg (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .load      (out_load),
        .load_data (out_data),
        .ready     (bus.WREADY),
        .data      (wbyte),
        .valid     (wvalid)
    );

    assign bus.WByt0     = wbyte;
    assign bus.WVALID    = wvalid;
    assign bus.OBJ_READY = obj_ready;
    assign bus.BUSY      = (state != IDLE);
    assign bus.HDR_DONE  = hdr_done;
    assign bus.FINISH    = (state == DONE);
    assign bus.BC        = bc;

endmodule

// File: tb/tb_global_header_writer.sv
// -----------------------------------------------------------------------------
// tb_global_header_writer
// Directed bench for global_header_writer (BYTES_PER_OBJ = 8). One process
// drives inputs on the falling edge and samples outputs 2 ns later; every
// downstream transfer is captured and compared with the stream expected for
// the frame (header fields, then object bytes 0,1,2,...).
// -----------------------------------------------------------------------------
module tb_global_header_writer;
    import global_header_writer_pkg::*;

    localparam int BPO = 8;

    logic ACLK = 1'b0;
    logic ARESETn;
    always #5 ACLK = ~ACLK;

    global_header_writer_if bus ();

    global_header_writer #(.BYTES_PER_OBJ(BPO)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Capture and bookkeeping for the current frame
    byte_t out_q[$];
    int    out_cyc[$];
    int    cyc = 0;
    int    start_cyc;
    int    up_idx, up_len, up_hs;
    bit    rdy_seen;
    int    hdr_pulses, fin_pulses, hdr_cyc, fin_cyc;
    int    stall_errs, bc_errs, bubbles;
    bit    prev_stall;
    byte_t prev_byte;

    // Stimulus controls
    bit    bp_en, starve_en, ign_en, ign_done, start_now;
    int    starve_left;
    byte_t f_cnt, f_x, f_y, f_ang, f_zoom;
    bit    bp_pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic drive();
        bit starving;
        cyc++;
        bus.WREADY    = bp_en ? bp_pat[cyc % 8] : 1'b1;
        bus.START     = start_now;
        bus.OBJ_COUNT = f_cnt;
        bus.X_CENTER  = f_x;
        bus.Y_CENTER  = f_y;
        bus.ANGLE     = f_ang;
        bus.ZOOM      = f_zoom;
        if (ign_en && !ign_done && up_idx == 8) begin
            bus.START     = 1'b1;
            bus.OBJ_COUNT = 8'h07;
            bus.X_CENTER  = 8'hA1;
            bus.Y_CENTER  = 8'hA2;
            bus.ANGLE     = 8'hA3;
            bus.ZOOM      = 8'hA4;
            ign_done      = 1'b1;
        end
        starving = starve_en && (up_idx == 5) && (starve_left > 0);
        if (starving) starve_left--;
        bus.OBJ_VALID = (up_idx < up_len) && !starving;
        bus.OBJ_DATA  = byte_t'(up_idx);
    endtask

    task automatic sample();
        if (prev_stall && (!bus.WVALID || bus.WByt0 !== prev_byte)) stall_errs++;
        prev_stall = bus.WVALID && !bus.WREADY;
        prev_byte  = bus.WByt0;
        if (bus.WVALID && out_q.size() < int'(HDR_LEN) && bus.BC !== 3'(out_q.size())) bc_errs++;
        if (out_q.size() >= int'(HDR_LEN) && bus.BC !== 3'd0) bc_errs++;
        if (!bus.WVALID && out_q.size() > int'(HDR_LEN) && out_q.size() < int'(HDR_LEN) + up_len)
            bubbles++;
        if (bus.OBJ_READY) rdy_seen = 1'b1;
        if (bus.HDR_DONE) begin hdr_pulses++; hdr_cyc = cyc; end
        if (bus.FINISH)   begin fin_pulses++; fin_cyc = cyc; end
        if (bus.WVALID && bus.WREADY) begin
            out_q.push_back(bus.WByt0);
            out_cyc.push_back(cyc);
        end
        if (bus.OBJ_VALID && bus.OBJ_READY) begin
            up_idx++;
            up_hs++;
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
        drive();
        #2;
        sample();
    endtask

    function automatic int last_push();
        return (out_cyc.size() > 0) ? out_cyc[out_cyc.size()-1] : -100;
    endfunction

    task automatic begin_frame(input byte_t c, x, y, a, z, input bit bp, starve, ign);
        out_q.delete();
        out_cyc.delete();
        up_idx = 0; up_len = int'(c) * BPO; up_hs = 0; rdy_seen = 1'b0;
        hdr_pulses = 0; fin_pulses = 0; hdr_cyc = -1; fin_cyc = -1;
        stall_errs = 0; bc_errs = 0; bubbles = 0; prev_stall = 1'b0;
        bp_en = bp; starve_en = starve; starve_left = 3; ign_en = ign; ign_done = 1'b0;
        f_cnt = c; f_x = x; f_y = y; f_ang = a; f_zoom = z;
        start_now = 1'b1;
        tick();
        start_cyc = cyc;
        start_now = 1'b0;
        // Field inputs change after START; the frame must not see this.
        f_cnt = 8'hEE; f_x = 8'hEE; f_y = 8'hEE; f_ang = 8'hEE; f_zoom = 8'hEE;
    endtask

    task automatic run_frame(input byte_t c, x, y, a, z, input bit bp, starve, ign);
        begin_frame(c, x, y, a, z, bp, starve, ign);
        for (int n = 0; n < 600 && fin_pulses == 0; n++) tick();
        repeat (4) tick();
    endtask

    task automatic check_stream(input string tag, input byte_t c, x, y, a, z);
        byte_t exp_q[$];
        exp_q.push_back(c);
        exp_q.push_back(x);
        exp_q.push_back(y);
        exp_q.push_back(a);
        exp_q.push_back(z);
        for (int i = 0; i < int'(c) * BPO; i++) exp_q.push_back(byte_t'(i));
        check({tag, " length"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check($sformatf("%s byte%0d", tag, i), out_q[i], exp_q[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETn       = 1'b0;
        bus.START     = 1'b0;
        bus.OBJ_COUNT = '0;
        bus.X_CENTER  = '0;
        bus.Y_CENTER  = '0;
        bus.ANGLE     = '0;
        bus.ZOOM      = '0;
        bus.OBJ_DATA  = '0;
        bus.OBJ_VALID = 1'b0;
        bus.WREADY    = 1'b0;

        // Reset state
        repeat (3) @(negedge ACLK);
        #2;
        check("rst WVALID",    bus.WVALID,    1'b0);
        check("rst WByt0",     bus.WByt0,     8'h00);
        check("rst BUSY",      bus.BUSY,      1'b0);
        check("rst HDR_DONE",  bus.HDR_DONE,  1'b0);
        check("rst FINISH",    bus.FINISH,    1'b0);
        check("rst BC",        bus.BC,        3'd0);
        check("rst OBJ_READY", bus.OBJ_READY, 1'b0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        tick();

        // Header only
        run_frame(8'h00, 8'h40, 8'h30, 8'h10, 8'h02, 1'b0, 1'b0, 1'b0);
        check_stream("hdr_only", 8'h00, 8'h40, 8'h30, 8'h10, 8'h02);
        check("hdr_only first byte latency", (out_cyc.size() > 0) ? out_cyc[0] - start_cyc : -1, 1);
        check("hdr_only header span", (out_cyc.size() >= 5) ? out_cyc[4] - out_cyc[0] : -1, 4);
        check("hdr_only HDR_DONE count", hdr_pulses, 1);
        check("hdr_only HDR_DONE timing", hdr_cyc, last_push() + 1);
        check("hdr_only FINISH count", fin_pulses, 1);
        check("hdr_only FINISH timing", fin_cyc, last_push() + 1);
        check("hdr_only OBJ_READY seen", rdy_seen, 1'b0);
        check("hdr_only BC tracking errs", bc_errs, 0);
        check("hdr_only BUSY after", bus.BUSY, 1'b0);

        // Full frame, 2 objects x 8 bytes, no stalls
        run_frame(8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
        check_stream("full", 8'h02, 8'h11, 8'h22, 8'h33, 8'h44);
        check("full upstream handshakes", up_hs, 16);
        check("full object span", (out_cyc.size() == 21) ? out_cyc[20] - out_cyc[5] : -1, 15);
        check("full bubbles", bubbles, 0);
        check("full HDR_DONE count", hdr_pulses, 1);
        check("full FINISH count", fin_pulses, 1);
        check("full FINISH timing", fin_cyc, last_push() + 1);
        check("full BC tracking errs", bc_errs, 0);
        check("full BUSY after", bus.BUSY, 1'b0);

        // Backpressure
        run_frame(8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 1'b0, 1'b0);
        check_stream("bp", 8'h02, 8'h11, 8'h22, 8'h33, 8'h44);
        check("bp stall hold errs", stall_errs, 0);
        check("bp upstream handshakes", up_hs, 16);
        check("bp FINISH count", fin_pulses, 1);
        check("bp BC tracking errs", bc_errs, 0);

        // Upstream starvation for 3 cycles mid-object
        run_frame(8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b1, 1'b0);
        check_stream("starve", 8'h02, 8'h11, 8'h22, 8'h33, 8'h44);
        check("starve bubbles", bubbles, 3);
        check("starve upstream handshakes", up_hs, 16);
        check("starve FINISH count", fin_pulses, 1);

        // START pulsed during OBJ with different fields
        run_frame(8'h02, 8'h5A, 8'h6B, 8'h7C, 8'h8D, 1'b0, 1'b0, 1'b1);
        check("ign START issued", ign_done, 1'b1);
        check_stream("ign", 8'h02, 8'h5A, 8'h6B, 8'h7C, 8'h8D);
        check("ign FINISH count", fin_pulses, 1);
        check("ign HDR_DONE count", hdr_pulses, 1);
        check("ign BUSY after", bus.BUSY, 1'b0);

        // Reset during header byte 2
        begin_frame(8'h00, 8'h55, 8'h66, 8'h77, 8'h88, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 20 && out_q.size() < 2; n++) tick();
        tick();
        check("midrst BC before", bus.BC, 3'd2);
        check("midrst WVALID before", bus.WVALID, 1'b1);
        check("midrst WByt0 before", bus.WByt0, 8'h66);
        #1;
        ARESETn = 1'b0;
        #1;
        check("midrst WVALID", bus.WVALID, 1'b0);
        check("midrst WByt0", bus.WByt0, 8'h00);
        check("midrst BUSY", bus.BUSY, 1'b0);
        check("midrst BC", bus.BC, 3'd0);
        check("midrst HDR_DONE", bus.HDR_DONE, 1'b0);
        check("midrst FINISH", bus.FINISH, 1'b0);
        check("midrst OBJ_READY", bus.OBJ_READY, 1'b0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        tick();
        check("midrst BUSY after release", bus.BUSY, 1'b0);
        check("midrst WVALID after release", bus.WVALID, 1'b0);
        run_frame(8'h01, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 1'b0, 1'b0, 1'b0);
        check_stream("restart", 8'h01, 8'h9A, 8'hBC, 8'hDE, 8'hF0);
        check("restart FINISH count", fin_pulses, 1);
        check("restart upstream handshakes", up_hs, 8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
